// File: rtl/bh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bh_pkg
//  Description : Shared definitions for the Bluetooth UART send/receive pair:
//                receiver FSM states, command byte codes and bit-timing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bh_pkg;

  // Receiver FSM state encoding
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  // Single-byte ASCII commands
  localparam logic [7:0] CMD_SET_ALL  = 8'h41;  // 'A'
  localparam logic [7:0] CMD_CLR_ALL  = 8'h5A;  // 'Z'
  localparam logic [7:0] CMD_TOG_BASE = 8'h30;  // '0'; '0'..'3' toggle led[n]

  // Clock cycles per serial bit; both directions must use this same value
  function automatic int bit_cyc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bh_recv_if.sv
`default_nettype none
// ============================================================================
//  Module      : bh_recv_if
//  Description : Serial line and receive-side result signals of bh_recv.
//                slave = the receiver, master = whatever drives the line and
//                consumes bytes / LED state.
//  Revision    : 1.0  initial release
// ============================================================================
interface bh_recv_if;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [3:0] led;

  modport master (
    output uart_rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  led
  );

  modport slave (
    input  uart_rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output led
  );
endinterface
`default_nettype wire

// File: rtl/bh_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bh_uart_rx
//  Description : 8N1 UART receiver: 2-flop input synchronizer, mid-bit
//                sampling FSM with baud counter, byte/frame-error pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module bh_uart_rx
  import bh_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC);

  // Counter reload values: the counter runs down and a sample is taken when
  // it reaches zero, so a load of N-1 places the next sample N cycles later.
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(BIT_CYC - 1);

  if (BIT_CYC < 4) begin : g_bit_cyc_check
    $error("bh_uart_rx: CLK_FREQ/BAUD must be at least 4");
  end

  logic [1:0]    sync_q;
  logic          rxd_s;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          tick;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], uart_rxd};
  end

  assign rxd_s = sync_q[1];
  assign tick  = (cnt_q == '0);

  // State, counter, shift register and output pulse registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: sample at each counter zero, reload on every sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = HALF_LD;
        end
      end

      START: begin
        if (tick) begin
          if (rxd_s) begin
            // Line went back high before mid-start-bit: glitch
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            cnt_d   = BIT_LD;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DATA: begin
        if (tick) begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = BIT_LD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: rtl/bh_recv.sv
`default_nettype none
// ============================================================================
//  Module      : bh_recv
//  Description : Bluetooth UART receive path: byte recovery plus single-byte
//                ASCII command decoder driving a 4-bit LED register.
//  Revision    : 1.0  initial release
// ============================================================================
module bh_recv
  import bh_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  bh_recv_if.slave    bus
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [3:0] led_q, led_d;

  bh_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (bus.uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Command decode; only the byte accompanied by rx_valid is acted on
  always_comb begin
    led_d = led_q;
    if (rx_valid) begin
      if (rx_data == CMD_SET_ALL) begin
        led_d = 4'hF;
      end else if (rx_data == CMD_CLR_ALL) begin
        led_d = 4'h0;
      end else if (rx_data[7:2] == CMD_TOG_BASE[7:2]) begin
        led_d[rx_data[1:0]] = ~led_q[rx_data[1:0]];
      end
    end
  end

  // LED register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) led_q <= 4'h0;
    else            led_q <= led_d;
  end

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_bh_recv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bh_recv
//  Description : Self-checking bench for bh_recv with 16 clocks per bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bh_recv;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int BIT_CYC  = 16;
  // Pin fall to rx_valid/frame_err: 2 synchronizer cycles + HALF + 9*BIT_CYC + 1
  localparam int LAT      = 2 + 153;

  logic clk;
  logic rst_n;

  bh_recv_if bus ();

  bh_recv #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  int last_valid_cyc = 0;
  int last_ferr_cyc  = 0;
  int vq[$];
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      vq.push_back(cyc);
    end
    if (bus.frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (bus.rx_valid && bus.frame_err) n_both++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Hold the line at v for one bit time; starts and ends 1 ns after a posedge
  task automatic drive_bit(input logic v);
    bus.uart_rxd = v;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  int fall_cyc = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    for (int i = 0; i < stop_bits; i++) drive_bit(stop_v);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_ok;
    logic [3:0] exp_led;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, sz0;

    vecs[0] = '{8'hA5, 1'b1, 4'h0, 8'hA5, 1, 0};  // not a command
    vecs[1] = '{8'h31, 1'b1, 4'h2, 8'h31, 1, 0};  // toggle led[1]
    vecs[2] = '{8'h31, 1'b1, 4'h0, 8'h31, 1, 0};  // toggle back
    vecs[3] = '{8'h41, 1'b1, 4'hF, 8'h41, 1, 0};  // set all
    vecs[4] = '{8'h5A, 1'b1, 4'h0, 8'h5A, 1, 0};  // clear all
    vecs[5] = '{8'h33, 1'b1, 4'h8, 8'h33, 1, 0};  // toggle led[3]
    vecs[6] = '{8'h41, 1'b0, 4'h8, 8'h33, 0, 1};  // stop low: nothing changes
    vecs[7] = '{8'h30, 1'b1, 4'h9, 8'h30, 1, 0};  // toggle led[0]

    bus.uart_rxd = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", {24'h0, bus.rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("reset_frame_err", {31'h0, bus.frame_err}, 32'h0);
    check("reset_led", {28'h0, bus.led}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(vecs[k].b, vecs[k].stop_ok, vecs[k].stop_ok ? 1 : 3);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check($sformatf("vec%0d_led", k), {28'h0, bus.led}, {28'h0, vecs[k].exp_led});
      check($sformatf("vec%0d_rx_data", k), {24'h0, bus.rx_data}, {24'h0, vecs[k].exp_data});
      check($sformatf("vec%0d_valid_count", k), n_valid - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_ferr_count", k), n_ferr - f0, vecs[k].exp_ferr);
      if (vecs[k].stop_ok)
        check($sformatf("vec%0d_valid_latency", k), last_valid_cyc - fall_cyc, LAT);
      else
        check($sformatf("vec%0d_ferr_latency", k), last_ferr_cyc - fall_cyc, LAT);
    end

    // Glitch: 5-cycle low pulse must produce nothing
    v0 = n_valid;
    f0 = n_ferr;
    bus.uart_rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.uart_rxd = 1'b1;
    repeat (3) drive_bit(1'b1);
    check("glitch_valid_count", n_valid - v0, 0);
    check("glitch_ferr_count", n_ferr - f0, 0);
    check("glitch_led", {28'h0, bus.led}, 32'h9);

    // Back-to-back frames after clearing the LEDs
    send_frame(8'h5A, 1'b1, 1);
    drive_bit(1'b1);
    v0  = n_valid;
    f0  = n_ferr;
    sz0 = vq.size();
    send_frame(8'h32, 1'b1, 1);
    send_frame(8'h33, 1'b1, 1);
    drive_bit(1'b1);
    check("b2b_valid_count", n_valid - v0, 2);
    check("b2b_ferr_count", n_ferr - f0, 0);
    if (vq.size() >= sz0 + 2)
      check("b2b_spacing", vq[sz0 + 1] - vq[sz0], 160);
    else
      check("b2b_spacing_missing", vq.size() - sz0, 2);
    check("b2b_led", {28'h0, bus.led}, 32'hC);
    check("b2b_rx_data", {24'h0, bus.rx_data}, 32'h33);

    // Reset during bit 4 of a frame
    v0 = n_valid;
    f0 = n_ferr;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    bus.uart_rxd = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.uart_rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_rx_data", {24'h0, bus.rx_data}, 32'h0);
    check("midrst_led", {28'h0, bus.led}, 32'h0);
    check("midrst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("midrst_frame_err", {31'h0, bus.frame_err}, 32'h0);
    repeat (12) drive_bit(1'b1);
    check("midrst_no_valid", n_valid - v0, 0);
    check("midrst_no_ferr", n_ferr - f0, 0);
    v0 = n_valid;
    send_frame(8'h5A, 1'b1, 1);
    drive_bit(1'b1);
    check("after_rst_rx_data", {24'h0, bus.rx_data}, 32'h5A);
    check("after_rst_valid_count", n_valid - v0, 1);
    check("after_rst_latency", last_valid_cyc - fall_cyc, LAT);

    check("valid_ferr_overlap", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
